// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two packet requesters and a shared UART TX FIFO.
//   req0_* / req1_* : valid/data/last from each requester, ready back to it
//   fifo_full       : FIFO back-pressure flag
//   fifo_wr/wdata   : FIFO write strobe and data
//   grant           : one-hot current owner (00 = idle)
//   trunc_err       : one-cycle pulse after a forced release at MAX_LEN
// master = requester/FIFO side (testbench), slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_last;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_last;
  logic                  req1_ready;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic [1:0]            grant;
  logic                  trunc_err;

  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, fifo_full,
    input  req0_ready, req1_ready, fifo_wr, fifo_wdata, grant, trunc_err
  );

  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, fifo_full,
    output req0_ready, req1_ready, fifo_wr, fifo_wdata, grant, trunc_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter in front of a shared UART TX FIFO.
// A requester owns the FIFO for a whole packet (until a word with last=1),
// or until MAX_LEN words have been written, in which case the grant is
// force-released and trunc_err pulses for one cycle. Contention in IDLE is
// resolved by a round-robin pointer that points away from the last owner.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-low reset
//   bus   : uart_tx_arbiter_if.slave handshake bundle
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.slave    bus
);

  // Counter only has to reach MAX_LEN-1; the MAX_LEN-th transfer releases.
  localparam int            CW       = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trunc_q, trunc_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  logic                  xfer, own_last;
  logic [DATA_WIDTH-1:0] own_data;

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    trunc_d         = 1'b0;
    xfer            = 1'b0;
    own_last        = 1'b0;
    own_data        = '0;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.fifo_wr     = 1'b0;
    bus.fifo_wdata  = '0;
    bus.grant       = 2'b00;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req0_valid && bus.req1_valid) state_d = ptr_q ? OWN1 : OWN0;
        else if (bus.req0_valid)              state_d = OWN0;
        else if (bus.req1_valid)              state_d = OWN1;
      end
      OWN0: begin
        bus.grant      = 2'b01;
        bus.req0_ready = !bus.fifo_full;
        xfer           = bus.req0_valid && !bus.fifo_full;
        own_last       = bus.req0_last;
        own_data       = bus.req0_data;
      end
      OWN1: begin
        bus.grant      = 2'b10;
        bus.req1_ready = !bus.fifo_full;
        xfer           = bus.req1_valid && !bus.fifo_full;
        own_last       = bus.req1_last;
        own_data       = bus.req1_data;
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      bus.fifo_wr    = 1'b1;
      bus.fifo_wdata = own_data;
      cnt_d          = cnt_q + 1'b1;
      // last wins over truncation when both hit on the same word
      if (own_last || cnt_q == LAST_IDX) begin
        state_d = IDLE;
        ptr_d   = (state_q == OWN0);
        trunc_d = !own_last;
      end
    end

    // Keep the outward handshake quiet while reset is asserted, even before
    // the first edge has brought the state register to IDLE.
    if (!reset) begin
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.fifo_wr    = 1'b0;
      bus.fifo_wdata = '0;
      bus.grant      = 2'b00;
    end
  end

  assign bus.trunc_err = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_arbiter #(.DATA_WIDTH(8), .MAX_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then leave time for new inputs before sampling
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic v0, input logic [7:0] d0, input logic l0,
                     input logic v1, input logic [7:0] d1, input logic l1,
                     input logic ff);
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_last = l0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_last = l1;
    bus.fifo_full  = ff;
    #1;
  endtask

  // grant, ready0, ready1, wr, wdata, trunc in one call
  task automatic exp_out(input string tag, input logic [1:0] g, input logic r0,
                         input logic r1, input logic wr, input logic [7:0] wd,
                         input logic te);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".rdy0"},  32'(bus.req0_ready), 32'(r0));
    chk({tag, ".rdy1"},  32'(bus.req1_ready), 32'(r1));
    chk({tag, ".wr"},    32'(bus.fifo_wr), 32'(wr));
    chk({tag, ".wdata"}, 32'(bus.fifo_wdata), 32'(wd));
    chk({tag, ".trunc"}, 32'(bus.trunc_err), 32'(te));
  endtask

  initial begin
    // ---- reset: outputs quiet even with a requester active ----
    reset = 1'b0;
    drv(1, 8'hAA, 0, 1, 8'hBB, 0, 0);
    exp_out("rst_pre", 2'b00, 0, 0, 0, 8'h00, 0);
    cyc(); cyc();
    exp_out("rst_hold", 2'b00, 0, 0, 0, 8'h00, 0);
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    exp_out("rst_rel", 2'b00, 0, 0, 0, 8'h00, 0);

    // ---- single packet, req0: 11 22 33(last) ----
    cyc(); drv(1, 8'h11, 0, 0, 0, 0, 0);
    exp_out("sp_idle", 2'b00, 0, 0, 0, 8'h00, 0);
    cyc(); exp_out("sp_w0", 2'b01, 1, 0, 1, 8'h11, 0);
    cyc(); drv(1, 8'h22, 0, 0, 0, 0, 0);
    exp_out("sp_w1", 2'b01, 1, 0, 1, 8'h22, 0);
    cyc(); drv(1, 8'h33, 1, 0, 0, 0, 0);
    exp_out("sp_w2", 2'b01, 1, 0, 1, 8'h33, 0);
    cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    exp_out("sp_rel", 2'b00, 0, 0, 0, 8'h00, 0);

    // ---- contention from reset: order req0, req1, req0, req1 ----
    reset = 1'b0; cyc(); reset = 1'b1;
    drv(1, 8'hA0, 0, 1, 8'hB0, 0, 0);
    exp_out("ct_idle0", 2'b00, 0, 0, 0, 8'h00, 0);
    cyc(); exp_out("ct_a0", 2'b01, 1, 0, 1, 8'hA0, 0);
    cyc(); drv(1, 8'hA1, 1, 1, 8'hB0, 1, 0);  // req1 last ignored while not owner
    exp_out("ct_a1", 2'b01, 1, 0, 1, 8'hA1, 0);
    cyc(); drv(1, 8'hC0, 0, 1, 8'hB0, 0, 0);
    exp_out("ct_idle1", 2'b00, 0, 0, 0, 8'h00, 0);
    cyc(); exp_out("ct_b0", 2'b10, 0, 1, 1, 8'hB0, 0);
    cyc(); drv(1, 8'hC0, 0, 1, 8'hB1, 1, 0);
    exp_out("ct_b1", 2'b10, 0, 1, 1, 8'hB1, 0);
    cyc(); drv(1, 8'hC0, 0, 1, 8'hD0, 0, 0);
    exp_out("ct_idle2", 2'b00, 0, 0, 0, 8'h00, 0);
    cyc(); exp_out("ct_c0", 2'b01, 1, 0, 1, 8'hC0, 0);
    cyc(); drv(1, 8'hC1, 1, 1, 8'hD0, 0, 0);
    exp_out("ct_c1", 2'b01, 1, 0, 1, 8'hC1, 0);
    cyc(); drv(0, 0, 0, 1, 8'hD0, 0, 0);
    exp_out("ct_idle3", 2'b00, 0, 0, 0, 8'h00, 0);
    cyc(); exp_out("ct_d0", 2'b10, 0, 1, 1, 8'hD0, 0);
    cyc(); drv(0, 0, 0, 1, 8'hD1, 1, 0);
    exp_out("ct_d1", 2'b10, 0, 1, 1, 8'hD1, 0);
    cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    exp_out("ct_rel", 2'b00, 0, 0, 0, 8'h00, 0);

    // ---- backpressure: req0 51 52 <full x4> 53(last) ----
    drv(1, 8'h51, 0, 0, 0, 0, 0);
    cyc(); exp_out("bp_w0", 2'b01, 1, 0, 1, 8'h51, 0);
    cyc(); drv(1, 8'h52, 0, 0, 0, 0, 0);
    exp_out("bp_w1", 2'b01, 1, 0, 1, 8'h52, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); drv(1, 8'h53, 1, 0, 0, 0, 1);
      exp_out("bp_stall", 2'b01, 0, 0, 0, 8'h00, 0);
    end
    cyc(); drv(1, 8'h53, 1, 0, 0, 0, 0);
    exp_out("bp_w2", 2'b01, 1, 0, 1, 8'h53, 0);
    cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    exp_out("bp_rel", 2'b00, 0, 0, 0, 8'h00, 0);

    // ---- truncation at MAX_LEN=4: req1 streams 61..66 ----
    drv(0, 0, 0, 1, 8'h61, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); drv(0, 0, 0, 1, 8'(8'h61 + i), 0, 0);
      exp_out("tr_w", 2'b10, 0, 1, 1, 8'(8'h61 + i), 0);
    end
    cyc(); drv(0, 0, 0, 1, 8'h65, 0, 0);
    exp_out("tr_idle", 2'b00, 0, 0, 0, 8'h00, 1);
    cyc(); exp_out("tr_w4", 2'b10, 0, 1, 1, 8'h65, 0);
    cyc(); drv(0, 0, 0, 1, 8'h66, 1, 0);
    exp_out("tr_w5", 2'b10, 0, 1, 1, 8'h66, 0);
    cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    exp_out("tr_rel", 2'b00, 0, 0, 0, 8'h00, 0);

    // ---- boundary: 4th word carries last -> no trunc_err ----
    drv(1, 8'h71, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); drv(1, 8'(8'h71 + i), (i == 3), 0, 0, 0, 0);
      exp_out("bd_w", 2'b01, 1, 0, 1, 8'(8'h71 + i), 0);
    end
    cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    exp_out("bd_rel", 2'b00, 0, 0, 0, 8'h00, 0);
    cyc(); exp_out("bd_after", 2'b00, 0, 0, 0, 8'h00, 0);

    // ---- reset mid-packet: req1 81 82, reset, then both valid -> req0 ----
    drv(0, 0, 0, 1, 8'h81, 0, 0);
    cyc(); exp_out("rm_w0", 2'b10, 0, 1, 1, 8'h81, 0);
    cyc(); drv(0, 0, 0, 1, 8'h82, 0, 0);
    exp_out("rm_w1", 2'b10, 0, 1, 1, 8'h82, 0);
    cyc(); reset = 1'b0; drv(0, 0, 0, 1, 8'h83, 0, 0);
    exp_out("rm_rst", 2'b00, 0, 0, 0, 8'h00, 0);
    cyc(); reset = 1'b1; drv(1, 8'h91, 1, 1, 8'h83, 0, 0);
    exp_out("rm_idle", 2'b00, 0, 0, 0, 8'h00, 0);
    cyc(); exp_out("rm_g0", 2'b01, 1, 0, 1, 8'h91, 0);
    cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    exp_out("rm_rel", 2'b00, 0, 0, 0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each byte/word written to the shared TX FIFO.
REQ-002 Parameter MAX_LEN, default 16: maximum transfers per grant before forced release; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 req0_valid  input  1  requester 0 has a word on req0_data.
REQ-006 req0_data  input  DATA_WIDTH  requester 0 word.
REQ-007 req0_last  input  1  marks the final word of requester 0's packet; qualified by req0_valid.
REQ-008 req0_ready  output  1  requester 0 word accepted this cycle when high together with req0_valid.
REQ-009 req1_valid, req1_data, req1_last, req1_ready: same directions, widths and meanings as REQ-005..REQ-008, for requester 1.
REQ-010 fifo_full  input  1  shared TX FIFO full flag.
REQ-011 fifo_wr  output  1  write strobe to shared TX FIFO.
REQ-012 fifo_wdata  output  DATA_WIDTH  write data to shared TX FIFO.
REQ-013 grant  output  2  one-hot current owner: bit0 = requester 0, bit1 = requester 1; 2'b00 when idle.
REQ-014 trunc_err  output  1  one-cycle pulse when a grant is force-released at MAX_LEN.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, OWN0, OWN1; grant SHALL be 2'b00, 2'b01 or 2'b10 respectively.
REQ-016 In IDLE with only reqN_valid high, the next state SHALL be OWNN.
REQ-017 In IDLE with both valids high, the next state SHALL be OWN of the requester indicated by the round-robin pointer; the pointer SHALL be 0 after reset.
REQ-018 In IDLE, req0_ready, req1_ready and fifo_wr SHALL be 0.
REQ-019 In OWNN, reqN_ready SHALL equal !fifo_full combinationally, and the other requester's ready SHALL be 0.
REQ-020 A transfer SHALL occur in any cycle where the owner's valid and ready are both 1; fifo_wr SHALL be 1 in exactly those cycles and fifo_wdata SHALL equal the owner's data in the same cycle.
REQ-021 fifo_wr SHALL never be 1 in a cycle where fifo_full is 1.
REQ-022 fifo_wdata SHALL be all zeros when fifo_wr is 0.
REQ-023 A per-grant transfer counter SHALL clear to 0 on entry to OWN0/OWN1 and increment by 1 on each transfer.
REQ-024 A transfer with last=1 SHALL cause transition to IDLE on the next edge and set the pointer to the other requester.
REQ-025 A transfer with last=0 that is the MAX_LEN-th of the grant SHALL cause transition to IDLE, set the pointer to the other requester, and assert trunc_err for exactly the following cycle.
REQ-026 If last=1 coincides with the MAX_LEN-th transfer, the grant SHALL release normally and trunc_err SHALL stay 0.
REQ-027 While owned, owner valid low or fifo_full high SHALL stall without releasing the grant, with no timeout.
REQ-028 Valid or last on the non-owner SHALL be ignored and SHALL NOT alter state or counter.
REQ-029 A grant SHALL take effect one cycle after IDLE detects a request; there SHALL be at least one IDLE cycle between consecutive grants.

Reset
REQ-030 When reset=0 at a rising edge, the state SHALL go to IDLE, pointer to 0, counter to 0, and trunc_err to 0, regardless of any packet in progress; that packet is abandoned.
REQ-031 During and immediately after reset, grant, req0_ready, req1_ready, fifo_wr and fifo_wdata SHALL all be 0.

Verification
REQ-032 Single packet: req0 sends 3 words (0x11, 0x22, 0x33 with last), fifo_full=0 -> grant=01 one cycle after valid, three consecutive fifo_wr with matching data, IDLE the cycle after 0x33, trunc_err=0.
REQ-033 Contention: both valid from reset, each with 2-word packets -> owner order req0, req1, req0, req1; at least one IDLE cycle between grants; req1 never ready while grant=01.
REQ-034 Backpressure: fifo_full=1 for 4 cycles mid-packet -> fifo_wr=0 and ready=0 those cycles, grant held, no word lost or duplicated.
REQ-035 Truncation: MAX_LEN=4, req1 streams 6 words without last -> 4 writes, IDLE, trunc_err pulse of exactly 1 cycle; with req0 idle, req1 is regranted and the remaining 2 words are written.
REQ-036 Boundary: MAX_LEN=4, 4th word carries last -> release with trunc_err=0.
REQ-037 Reset mid-packet: reset=0 after the 2nd of 5 words -> next cycle grant=00 and fifo_wr=0; after release with both valid, req0 is granted first.
